// File: rtl/prod_accumulator.sv
// Purpose : sums a frame of FRAME_LEN unsigned 6-bit multiplier products and presents the total with an overflow flag.
// Latency : the result is registered on the final accept edge, so out_valid is visible in the next cycle.
// Backpressure: in_ready is low for the whole time a result is held; a new frame starts only after out_valid && out_ready.
//
// Ports:
//   clk, rst_n         - core clock, asynchronous active-low reset
//   clear              - synchronous flush of the frame and any held result (wins over handshakes)
//   in_valid/in_ready  - product handshake, in_prod is the 6-bit product p5..p0
//   out_valid/out_ready- result handshake, out_sum/out_ovf are the frame total and overflow flag
//   frame_cnt          - number of products accepted so far in the current frame
//
// Optional feature: define PROD_ACC_SAT_EN so that the accumulator clamps at 2^ACC_W-1
// on overflow instead of wrapping. out_ovf is reported the same way in both builds.
module prod_accumulator #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [3:0]       frame_cnt
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [3:0]       LAST_CNT = 4'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic             ovf_q,       ovf_d;
    logic [3:0]       cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic             out_ovf_q,   out_ovf_d;

    // One extra bit holds the carry out of the accumulator.
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic             accept;
    logic             last_accept;

    assign sum_ext  = {1'b0, acc_q} + {{(ACC_W-5){1'b0}}, in_prod};
    assign carry    = sum_ext[ACC_W];
    assign ovf_next = ovf_q | carry;

`ifdef PROD_ACC_SAT_EN
    // Once clamped, acc sits at ACC_MAX; any further non-zero product carries
    // again and re-clamps, and a zero product leaves it at ACC_MAX.
    assign acc_next = carry ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    // in_ready_q is 0 only in HOLD and in the single cycle after reset release,
    // so the state term is redundant but keeps HOLD strictly closed to input.
    assign accept      = in_valid && in_ready_q && (state_q == ST_ACC);
    assign last_accept = accept && (cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    // Raises in_ready on the first edge after reset release.
                    in_ready_d = 1'b1;
                    if (last_accept) begin
                        out_sum_d   = acc_next;
                        out_ovf_d   = ovf_next;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_HOLD;
                        acc_d       = '0;
                        ovf_d       = 1'b0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        acc_d = acc_next;
                        ovf_d = ovf_next;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    // Consume edge only reopens the input; a product offered
                    // in this same cycle waits for the next one.
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Purpose : exercises prod_accumulator in two configurations (4 x 9-bit and 2 x 6-bit).
// Latency : expected results are queued at the final product and popped when the result is consumed.
// Backpressure: out_ready is held low in some frames to check that results stay stable and input stays closed.
module tb_prod_accumulator;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [5:0] a_in_prod;
    logic [8:0] a_out_sum;
    logic [3:0] a_frame_cnt;

    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [5:0] b_in_prod;
    logic [5:0] b_out_sum;
    logic [3:0] b_frame_cnt;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;

    prod_accumulator #(.FRAME_LEN(4), .ACC_W(9)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf), .frame_cnt(a_frame_cnt)
    );

    prod_accumulator #(.FRAME_LEN(2), .ACC_W(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf), .frame_cnt(b_frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Holds the product until the DUT accepts it; returns 1 time unit after the accept edge.
    task automatic send_a(input logic [5:0] p);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_prod  = p;
        while (!a_in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("a_accept_timeout", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [5:0] p);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_prod  = p;
        while (!b_in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("b_accept_timeout", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // Scoreboard monitors: every cycle a result is presented it must match the
    // head of the queue; the entry is retired on the consume cycle.
    always @(negedge clk) begin
        exp_t e;
        if (a_out_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_result actual_sum=%0d required=none", a_out_sum);
            end else begin
                e = qa[0];
                if (a_out_sum !== e.sum[8:0] || a_out_ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL a_result actual_sum=%0d ovf=%0d required_sum=%0d ovf=%0d",
                             a_out_sum, a_out_ovf, e.sum[8:0], e.ovf);
                end
                if (a_out_ready) void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_out_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_result actual_sum=%0d required=none", b_out_sum);
            end else begin
                e = qb[0];
                if (b_out_sum !== e.sum[5:0] || b_out_ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL b_result actual_sum=%0d ovf=%0d required_sum=%0d ovf=%0d",
                             b_out_sum, b_out_ovf, e.sum[5:0], e.ovf);
                end
                if (b_out_ready) void'(qb.pop_front());
            end
        end
    end

    initial begin
        logic [5:0] gap_prods [4];
        int n;
        gap_prods[0] = 6'd7; gap_prods[1] = 6'd0; gap_prods[2] = 6'd9; gap_prods[3] = 6'd6;

        rst_n = 1'b0;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_prod = '0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_prod = '0; b_out_ready = 1'b1;

        // Reset state: all outputs 0 during reset.
        #23;
        chk("rst_in_ready",  32'(a_in_ready),  32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_sum",   32'(a_out_sum),   32'd0);
        chk("rst_out_ovf",   32'(a_out_ovf),   32'd0);
        chk("rst_frame_cnt", 32'(a_frame_cnt), 32'd0);
        #4 rst_n = 1'b1;
        #1 chk("post_rst_in_ready_low", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_in_ready_high", 32'(a_in_ready), 32'd1);

        // Back-to-back full-scale products: 4 * 49 = 196, no overflow in 9 bits.
        send_a(6'd49); send_a(6'd49); send_a(6'd49);
        qa.push_back({16'd196, 1'b0});
        send_a(6'd49);
        chk("b2b_out_valid_next_cycle", 32'(a_out_valid), 32'd1);
        chk("b2b_in_ready_low",         32'(a_in_ready),  32'd0);
        @(posedge clk); #1;
        chk("b2b_consumed", 32'(a_out_valid), 32'd0);
        chk("b2b_reopen",   32'(a_in_ready),  32'd1);

        // Backpressure: result 10 held for 5 cycles with input closed.
        a_out_ready = 1'b0;
        send_a(6'd1); send_a(6'd2); send_a(6'd3);
        qa.push_back({16'd10, 1'b0});
        send_a(6'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
            chk("bp_out_sum",   32'(a_out_sum),   32'd10);
            chk("bp_in_ready",  32'(a_in_ready),  32'd0);
            @(posedge clk); #1;
        end
        // Offer a product together with out_ready: result consumed, product not taken.
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_prod   = 6'd5;
        @(posedge clk); #1;
        chk("bp_consume_valid", 32'(a_out_valid), 32'd0);
        chk("bp_consume_cnt",   32'(a_frame_cnt), 32'd0);
        chk("bp_consume_ready", 32'(a_in_ready),  32'd1);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_no_accept_in_hold", 32'(a_frame_cnt), 32'd0);

        // Gapped input: 7+0+9+6 = 22, frame_cnt moves only on accepts.
        for (int i = 0; i < 4; i++) begin
            chk("gap_cnt_before", 32'(a_frame_cnt), 32'(i));
            if (i == 3) qa.push_back({16'd22, 1'b0});
            send_a(gap_prods[i]);
            for (int k = 0; k < 3; k++) begin
                chk("gap_cnt_idle", 32'(a_frame_cnt), 32'((i + 1) % 4));
                @(posedge clk); #1;
            end
        end

        // Clear after 10, 20; product 5 offered in the clear cycle is dropped.
        send_a(6'd10); send_a(6'd20);
        chk("clr_cnt_before", 32'(a_frame_cnt), 32'd2);
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_prod = 6'd5;
        @(posedge clk); #1;
        a_clear = 1'b0; a_in_valid = 1'b0;
        chk("clr_cnt",      32'(a_frame_cnt), 32'd0);
        chk("clr_in_ready", 32'(a_in_ready),  32'd1);
        chk("clr_valid",    32'(a_out_valid), 32'd0);
        send_a(6'd1); send_a(6'd1); send_a(6'd1);
        qa.push_back({16'd4, 1'b0});
        send_a(6'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of HOLD.
        a_out_ready = 1'b0;
        send_a(6'd3); send_a(6'd3); send_a(6'd3);
        send_a(6'd3);
        chk("ar_hold_valid", 32'(a_out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(a_out_valid), 32'd0);
        chk("ar_out_sum",   32'(a_out_sum),   32'd0);
        chk("ar_in_ready",  32'(a_in_ready),  32'd0);
        chk("ar_frame_cnt", 32'(a_frame_cnt), 32'd0);
        // The held result was discarded, so its scoreboard entry goes too.
        qa.delete();
        #20;
        chk("ar_in_ready_during", 32'(a_in_ready), 32'd0);
        rst_n = 1'b1;
        #1 chk("ar_in_ready_release", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ar_in_ready_edge", 32'(a_in_ready), 32'd1);
        a_out_ready = 1'b1;

        // Narrow configuration: 49+49 = 98 overflows 6 bits.
        send_b(6'd49);
        chk("b_cnt_mid", 32'(b_frame_cnt), 32'd1);
`ifdef PROD_ACC_SAT_EN
        qb.push_back({16'd63, 1'b1});
`else
        qb.push_back({16'd34, 1'b1});
`endif
        send_b(6'd49);
        chk("b_out_valid", 32'(b_out_valid), 32'd1);
        chk("b_out_ovf",   32'(b_out_ovf),   32'd1);
        // Overflow flag must not leak into the next frame.
        send_b(6'd10);
        qb.push_back({16'd30, 1'b0});
        send_b(6'd20);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

- Sequential stage directly downstream of the 3x3 gate-level unsigned multiplier.
- Accepts its 6-bit product (0..49) over a valid/ready handshake and sums a fixed-length frame of `FRAME_LEN` products.
- Presents the frame total with an overflow flag over a second valid/ready handshake, then restarts.
- Acts as the accumulate half of the team's multiply-accumulate datapath.

## Interface

Parameters:
- `FRAME_LEN`, 4, number of products per frame; legal range 1..16.
- `ACC_W`, 9, accumulator and result width in bits; legal range 6..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame flush.
- `in_valid`  in  1  upstream product valid.
- `in_ready`  out  1  block can accept a product.
- `in_prod`  in  6  unsigned product p5..p0 from the multiplier.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  ACC_W  frame total.
- `out_ovf`  out  1  frame total exceeded 2^ACC_W-1.
- `frame_cnt`  out  4  products accepted in the current frame.

## Operation

- Two states:
  - ACC: collecting products.
  - HOLD: result presented.
- Reset / state:
  - Reset state is ACC.
  - All outputs are 0 during and immediately after reset, including `in_ready`.
- `in_ready` timing:
  - `in_ready` is registered.
  - It rises on the first `clk` edge after `rst_n` deasserts.
  - It is 1 throughout ACC and 0 throughout HOLD.
- Accept: an accept occurs on a `clk` edge where `in_valid && in_ready`.
  - `acc <= acc + in_prod`, computed at ACC_W+1 bits.
  - `frame_cnt` increments.
  - `ovf` sets sticky if the carry bit is 1.
- Final accept (`frame_cnt == FRAME_LEN-1` at the accept edge):
  - Load `out_sum`/`out_ovf` with the updated values.
  - Set `out_valid`.
  - Clear `in_ready`.
  - Go to HOLD.
  - Clear `acc`, `frame_cnt` and internal `ovf`.
- No accept in cycles where `in_valid` is 0; gaps are unlimited and leave state untouched.
- HOLD:
  - `out_sum`, `out_ovf` and `out_valid` are held stable until `out_valid && out_ready`.
  - On that edge: `out_valid` <= 0, `in_ready` <= 1, go to ACC.
  - No combinational ready path from `out_ready` to `in_ready`.
- `in_prod` values above 49 are not generated upstream; the block sums whatever arrives, without checking.
- `clear`:
  - Wins over any handshake in the same cycle.
  - Zeros `acc`, `frame_cnt`, `ovf`, `out_valid`, `out_sum` and `out_ovf`.
  - Forces ACC with `in_ready` = 1 on the next cycle.
  - A product offered in the `clear` cycle is dropped.
- `rst_n` low mid-frame or mid-HOLD discards everything immediately, without waiting for a clock.

## Timing

- Result latency: `out_valid` rises on the edge of the final accept and is visible in the following cycle.
- Minimum frame period: FRAME_LEN+1 cycles (FRAME_LEN accepts plus one HOLD handshake cycle).
- `FRAME_LEN`=1: every accept goes directly to HOLD; `frame_cnt` stays 0.
- Outputs are driven from registers only; no input-to-output combinational path.
- Simultaneous `out_ready` and `in_valid` in HOLD:
  - The result is consumed.
  - The product is not accepted.
  - The product must be held by upstream until the next cycle.

## Configuration

- Macro `PROD_ACC_SAT_EN`.
- Defined: on overflow `acc` clamps to 2^ACC_W-1 and stays there for the rest of the frame; `out_ovf` is still reported.
- Undefined: `acc` wraps modulo 2^ACC_W; `out_ovf` is the sticky carry.

## Test plan

- FRAME_LEN=4, ACC_W=9; products 49,49,49,49 back-to-back -> `out_sum`=196, `out_ovf`=0, `out_valid` high in the cycle after the 4th accept.
- FRAME_LEN=2, ACC_W=6; products 49,49:
  - Without the macro -> `out_sum`=34, `out_ovf`=1.
  - With `PROD_ACC_SAT_EN` -> `out_sum`=63, `out_ovf`=1.
- Backpressure; products 1,2,3,4 with `out_ready` low for 5 cycles -> `out_sum`=10 held stable, `in_ready`=0 throughout, next frame starts only after the consume edge.
- Gapped input; products 7,0,9,6 with 3 idle cycles between each -> `out_sum`=22, `frame_cnt` steps 0,1,2,3 only on accept edges.
- `clear` after two products (10,20), then products 1,1,1,1 -> `out_sum`=4, `out_ovf`=0; a product offered in the `clear` cycle is ignored.
- `rst_n` pulsed low mid-HOLD, asynchronous to `clk` -> `out_valid`, `out_sum`, `in_ready`, `frame_cnt` drop to 0 immediately; `in_ready`=1 one edge after release.
